// File: rtl/perf_window_sched.sv
// perf_window_sched: read-side scheduler for the account-performance path.
// Pops {account, A, T} from an FWFT FIFO, registers perf = A*T, keeps a
// WIN-deep sliding window and emits the account of minimum perf (ties go
// to the oldest entry) once per new entry after the window fills. One batch
// of BATCH entries runs per start pulse; downstream backpressure freezes the
// whole pipe.
// Ports:
//   clk2        sole clock
//   rst         synchronous reset, active-high
//   start       one-cycle pulse, begins a batch from IDLE
//   fifo_empty  FIFO read side empty
//   fifo_rdata  FIFO head entry {account, A, T}
//   fifo_rinc   pop strobe (combinational)
//   out_ready   downstream accepts out_account
//   out_valid   out_account valid
//   out_account account with minimum perf in the current window
//   busy        high in RUN or FLUSH
//   done        one-cycle pulse at batch end
module perf_window_sched #(
   parameter int DSIZE = 8,
   parameter int WIN   = 5,
   parameter int BATCH = 4000
) (
   input  logic               clk2,
   input  logic               rst,
   input  logic               start,
   input  logic               fifo_empty,
   input  logic [3*DSIZE-1:0] fifo_rdata,
   output logic               fifo_rinc,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [DSIZE-1:0]   out_account,
   output logic               busy,
   output logic               done
);
   localparam int PW   = 2 * DSIZE;
   localparam int CW   = $clog2(BATCH + 1);
   localparam int WW   = $clog2(WIN + 1);
   localparam int NOUT = BATCH - WIN + 1;

   if (WIN < 2) begin : g_win_chk
      $error("perf_window_sched: WIN must be >= 2");
   end
   if (BATCH < WIN) begin : g_batch_chk
      $error("perf_window_sched: BATCH must be >= WIN");
   end

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t            state;
   state_t            state_nx;
   logic [CW-1:0]     pop_cnt;
   logic [CW-1:0]     out_cnt;
   logic [WW-1:0]     win_cnt;
   logic [WW-1:0]     win_cnt_nx;
   logic              s1_valid;
   logic [DSIZE-1:0]  s1_acct;
   logic [PW-1:0]     s1_perf;
   logic [DSIZE-1:0]  win_acct [WIN];
   logic [PW-1:0]     win_perf [WIN];
   logic [PW-1:0]     prod;
   logic              stall;
   logic              shift;
   logic              full_nx;
   logic [DSIZE-1:0]  best_acct;
   logic [PW-1:0]     best_perf;

   assign stall = out_valid & ~out_ready;
   assign fifo_rinc = ~rst & (state == RUN) & ~fifo_empty & ~stall
                    & (pop_cnt < CW'(BATCH));
   assign shift = s1_valid & ~stall;
   assign busy = (state == RUN) | (state == FLUSH);
   assign done = (state == DONE);

   assign prod = PW'(fifo_rdata[2*DSIZE-1:DSIZE])
               * PW'(fifo_rdata[DSIZE-1:0]);

   assign win_cnt_nx = (win_cnt == WW'(WIN)) ? win_cnt : win_cnt + WW'(1);
   assign full_nx = shift & (win_cnt_nx == WW'(WIN));

   // Argmin over the post-shift window: slots 1..WIN-1 then s1 as newest.
   // Scanning oldest-first with a strict compare keeps ties on the oldest.
   always_comb begin
      best_acct = win_acct[1];
      best_perf = win_perf[1];
      for (int i = 2; i < WIN; i++) begin
         if (win_perf[i] < best_perf) begin
            best_acct = win_acct[i];
            best_perf = win_perf[i];
         end
      end
      if (s1_perf < best_perf) begin
         best_acct = s1_acct;
         best_perf = s1_perf;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (pop_cnt == CW'(BATCH)) state_nx = FLUSH;
         FLUSH:   if (out_cnt == CW'(NOUT)) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk2) begin
      if (rst) begin
         state       <= IDLE;
         pop_cnt     <= '0;
         out_cnt     <= '0;
         win_cnt     <= '0;
         s1_valid    <= 1'b0;
         s1_acct     <= '0;
         s1_perf     <= '0;
         out_valid   <= 1'b0;
         out_account <= '0;
         for (int i = 0; i < WIN; i++) begin
            win_acct[i] <= '0;
            win_perf[i] <= '0;
         end
      end else begin
         state <= state_nx;
         if (state == IDLE && start) begin
            pop_cnt <= '0;
            out_cnt <= '0;
            win_cnt <= '0;
            for (int i = 0; i < WIN; i++) begin
               win_acct[i] <= '0;
               win_perf[i] <= '0;
            end
         end else begin
            if (fifo_rinc) pop_cnt <= pop_cnt + CW'(1);
            if (out_valid && out_ready) out_cnt <= out_cnt + CW'(1);
            if (shift) begin
               for (int i = 0; i < WIN - 1; i++) begin
                  win_acct[i] <= win_acct[i+1];
                  win_perf[i] <= win_perf[i+1];
               end
               win_acct[WIN-1] <= s1_acct;
               win_perf[WIN-1] <= s1_perf;
               win_cnt <= win_cnt_nx;
            end
         end
         if (fifo_rinc) begin
            s1_valid <= 1'b1;
            s1_acct  <= fifo_rdata[3*DSIZE-1:2*DSIZE];
            s1_perf  <= prod;
         end else if (!stall) begin
            s1_valid <= 1'b0;
         end
         if (!stall) begin
            out_valid <= full_nx;
            if (full_nx) out_account <= best_acct;
         end
      end
   end

endmodule

// File: tb/tb_perf_window_sched.sv
// tb_perf_window_sched: directed bench for perf_window_sched with a
// window-argmin reference model and a per-cycle output checker.
module tb_perf_window_sched;
   localparam int DSIZE = 8;
   localparam int WIN   = 5;
   localparam int BATCH = 8;
   localparam int NOUT  = BATCH - WIN + 1;
   localparam int IW    = $clog2(BATCH);

   localparam logic [23:0] S1 [BATCH] = '{
      24'h010203, 24'h020101, 24'h030404, 24'h040505,
      24'h050303, 24'h060100, 24'h070909, 24'h080202};
   localparam logic [23:0] S2 [BATCH] = '{
      24'h010404, 24'h021001, 24'h030110, 24'h040802,
      24'h050208, 24'h060404, 24'h070404, 24'h080404};

   logic clk2 = 1'b0;
   logic rst, start, out_ready, gap;
   logic fifo_empty, fifo_rinc, out_valid, busy, done;
   logic [3*DSIZE-1:0] fifo_rdata;
   logic [DSIZE-1:0] out_account;

   logic [23:0] mem [BATCH];
   int head = BATCH;
   logic pop_now = 1'b0;
   int n_checks = 0;
   int n_fail = 0;
   int pop_idx = 0;
   int hs_cnt = 0;
   int done_cnt = 0;
   logic [DSIZE-1:0] exp_q [$];

   logic h0_ok = 1'b0, h0_full = 1'b0, h0_rdy = 1'b0;
   logic h1_ok = 1'b0, h1_full = 1'b0, h1_rdy = 1'b0;
   logic prev_stall = 1'b0;
   logic [DSIZE-1:0] prev_acct = '0;

   always #5 clk2 = ~clk2;

   assign fifo_empty = gap | (head >= BATCH);
   assign fifo_rdata = (head < BATCH) ? mem[head[IW-1:0]] : '0;

   perf_window_sched #(.DSIZE(DSIZE), .WIN(WIN), .BATCH(BATCH)) dut (
      .clk2(clk2),
      .rst(rst),
      .start(start),
      .fifo_empty(fifo_empty),
      .fifo_rdata(fifo_rdata),
      .fifo_rinc(fifo_rinc),
      .out_ready(out_ready),
      .out_valid(out_valid),
      .out_account(out_account),
      .busy(busy),
      .done(done)
   );

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  name, got, want, $time);
      end
   endtask

   function automatic int perf(input logic [23:0] e);
      return int'(e[15:8]) * int'(e[7:0]);
   endfunction

   // Reference: every full window of WIN consecutive entries yields the
   // account of its smallest product, earliest entry on ties.
   function automatic void build_exp();
      exp_q.delete();
      for (int n = WIN - 1; n < BATCH; n++) begin
         int b;
         b = n - WIN + 1;
         for (int i = n - WIN + 2; i <= n; i++)
            if (perf(mem[i]) < perf(mem[b])) b = i;
         exp_q.push_back(mem[b][23:16]);
      end
   endfunction

   // FIFO model: pop the head just after an edge that saw fifo_rinc.
   always @(posedge clk2) begin
      if (pop_now) begin
         #1;
         head = head + 1;
      end
   end

   always @(negedge clk2) begin
      pop_now = fifo_rinc;
      if (rst) begin
         chk("rinc_in_rst", fifo_rinc, 0);
         h0_ok = 0;
         h1_ok = 0;
         prev_stall = 0;
         pop_idx = 0;
         exp_q.delete();
      end else begin
         if (start && !busy) pop_idx = 0;
         if (prev_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_acct", out_account, prev_acct);
         end
         if (out_valid && !out_ready) chk("rinc_in_stall", fifo_rinc, 0);
         if (fifo_empty || !busy) chk("rinc_gate", fifo_rinc, 0);
         if (h1_ok && h0_ok && h1_rdy && h0_rdy)
            chk("latency_valid", out_valid, h1_full);
         if (out_valid && out_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) chk("extra_output", 1, 0);
            else chk("out_account", out_account, exp_q.pop_front());
         end
         if (done) done_cnt++;
         h1_ok = h0_ok;
         h1_full = h0_full;
         h1_rdy = h0_rdy;
         h0_ok = 1;
         h0_full = fifo_rinc && (pop_idx + 1 >= WIN);
         h0_rdy = out_ready;
         if (fifo_rinc) pop_idx++;
         prev_stall = out_valid && !out_ready;
         prev_acct = out_account;
      end
   end

   task automatic load(input int sc);
      if (sc == 1) mem = S1;
      else if (sc == 2) mem = S2;
      else
         for (int i = 0; i < BATCH; i++)
            mem[i] = {8'(11 + i), 8'd255, 8'd255};
      head = 0;
      build_exp();
      if (sc == 1) begin
         int lit [4];
         lit = '{2, 6, 6, 6};
         for (int i = 0; i < 4; i++) chk("model_s1", exp_q[i], lit[i]);
      end
      if (sc == 2) chk("model_tie", exp_q[0], 1);
      if (sc == 4) chk("model_max", exp_q[0], 11);
   endtask

   task automatic wait_pops(input int n);
      int c;
      c = 0;
      while (pop_idx < n && c < 100) begin
         @(negedge clk2);
         #1;
         c++;
      end
      chk("pop_timeout", pop_idx >= n, 1);
   endtask

   task automatic run_batch(input int mode, input int sc);
      int c;
      load(sc);
      hs_cnt = 0;
      done_cnt = 0;
      @(posedge clk2);
      #1 start = 1;
      @(posedge clk2);
      #1 start = 0;
      if (mode == 0) begin
         wait_pops(1);
         c = 0;
         while (pop_idx < BATCH && c < 50) begin
            @(negedge clk2);
            #1;
            c++;
         end
         chk("pop_gapless", c, BATCH - 1);
      end else if (mode == 3) begin
         wait_pops(5);
         @(posedge clk2);
         #1 out_ready = 0;
         c = 0;
         while (!out_valid && c < 20) begin
            @(negedge clk2);
            #1;
            c++;
         end
         for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
               @(negedge clk2);
               #1;
            end
            chk("stall_valid", out_valid, 1);
            chk("stall_acct", out_account, 2);
            chk("stall_rinc", fifo_rinc, 0);
         end
         @(posedge clk2);
         #1 out_ready = 1;
      end else if (mode == 4) begin
         c = 0;
         while (!dut.s1_valid && c < 20) begin
            @(negedge clk2);
            #1;
            c++;
         end
         chk("s1_perf_max", dut.s1_perf, 65025);
      end else if (mode == 5) begin
         wait_pops(6);
         @(posedge clk2);
         #1 rst = 1;
         @(posedge clk2);
         #1 rst = 0;
         @(negedge clk2);
         #1;
         chk("abort_valid", out_valid, 0);
         chk("abort_busy", busy, 0);
         chk("abort_done", done, 0);
         return;
      end else if (mode == 6) begin
         wait_pops(3);
         @(posedge clk2);
         #1 gap = 1;
         @(negedge clk2);
         #1;
         chk("gap_valid", out_valid, 0);
         chk("gap_rinc", fifo_rinc, 0);
         @(posedge clk2);
         #1 start = 1;
         @(posedge clk2);
         #1 start = 0;
         @(posedge clk2);
         @(posedge clk2);
         #1 gap = 0;
      end
      c = 0;
      while (done_cnt == 0 && c < 300) begin
         @(negedge clk2);
         #1;
         c++;
      end
      chk("done_seen", done_cnt > 0, 1);
      repeat (3) @(negedge clk2);
      #1;
      chk("done_once", done_cnt, 1);
      chk("out_count", hs_cnt, NOUT);
      chk("exp_drained", exp_q.size(), 0);
      chk("busy_after", busy, 0);
   endtask

   initial begin
      rst = 1;
      start = 0;
      out_ready = 1;
      gap = 0;
      repeat (3) @(posedge clk2);
      #1 rst = 0;
      @(negedge clk2);
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_acct", out_account, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      run_batch(0, 1);
      run_batch(0, 2);
      run_batch(3, 1);
      run_batch(4, 4);
      run_batch(5, 1);
      run_batch(0, 1);
      run_batch(6, 1);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
